music_sequencer_ctrl: RTL and testbench
=======================================

Name: music_sequencer_ctrl

Overview:
Controller that sequences the note-memory datapath for record and playback. It turns key presses into correctly spaced `ld_note` write pulses. During playback it holds `ld_play` and steps `note_counter` through the recorded notes at a fixed tempo. It sits between the board inputs (keys/switches, debounced upstream) and the datapath; `freq_out` from the datapath goes to the tone generator.

Parameters:
- `BEAT_CYCLES`, default 12500000: clk cycles per played note (4 notes/s at 50 MHz).
- `DEPTH`, default 16: note memory entries; address width is 4.
- `GAP_CYCLES`, default 2: minimum clk cycles between successive `ld_note` pulses (>= 2).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `rec_req` in 1: one-cycle pulse to enter RECORD.
- `play_req` in 1: one-cycle pulse to enter PLAY.
- `stop_req` in 1: one-cycle pulse to return to IDLE.
- `loop_en` in 1: level; 1 = repeat playback, 0 = play once.
- `key_valid` in 1: one-cycle pulse, a new note is present on the datapath note/octave inputs.
- `ld_note` out 1: write strobe to the datapath.
- `ld_play` out 1: playback select to the datapath.
- `note_counter` out 4: playback read address to the datapath.
- `note_count` out 5: number of notes stored, 0..16.
- `busy_rec` out 1: high in RECORD.
- `busy_play` out 1: high in PLAY.
- `beat` out 1: one-cycle pulse on each note advance.

Behaviour:
- Reset:
  - state = IDLE.
  - `ld_note`, `ld_play`, `beat`, `busy_rec`, `busy_play` = 0.
  - `note_counter` = 0, `note_count` = 0.
  - beat timer = 0, gap timer = 0.
  - Reset mid-record or mid-play aborts immediately, next cycle.
- States: IDLE, RECORD, PLAY. All outputs are registered.
- Request priority in any state: `stop_req` > `rec_req` > `play_req`.
- IDLE:
  - `rec_req` -> RECORD and clear `note_count` to 0.
  - `play_req` with `note_count` > 0 -> PLAY.
  - `play_req` with `note_count` = 0 is ignored.
- RECORD:
  - `key_valid` with gap timer = 0 and `note_count` < DEPTH:
    - `ld_note` = 1 for exactly the next cycle;
    - `note_count` += 1;
    - gap timer loaded with `GAP_CYCLES`.
  - `key_valid` while the gap timer is nonzero is dropped, not queued.
  - `key_valid` at `note_count` = 16 is dropped; the count saturates.
  - `ld_note` is never high on two consecutive cycles. The datapath needs a low cycle to re-arm its write enable.
  - `stop_req` -> IDLE, keeping `note_count`.
  - `play_req` -> PLAY if `note_count` > 0.
- PLAY:
  - `ld_play` = 1 throughout.
  - Entry:
    - playback index `idx` = 0;
    - `note_counter` = 1, because the datapath writes its first note at address 1 and subsequent notes at (n mod 16);
    - beat timer = 0.
  - Beat timer counts 0..BEAT_CYCLES-1. At the terminal count, `beat` pulses and `idx` advances.
  - `note_counter` = (`idx` + 1) mod 16, 4-bit wrap, so 15 -> 0.
  - At `idx` = `note_count` - 1 and terminal count:
    - `loop_en` = 1: `idx` -> 0, `note_counter` -> 1.
    - `loop_en` = 0: go to IDLE; `ld_play` drops the next cycle.
  - `stop_req` -> IDLE on the next cycle; `ld_play` = 0, `note_counter` held.
  - `rec_req` -> RECORD, which clears `note_count`.
  - `key_valid` is ignored.
- `loop_en` is sampled only at the last-note terminal count.
- `ld_note` and `ld_play` are never high in the same cycle.
- Timers are wide enough for `BEAT_CYCLES`, computed with `$clog2`.

Decomposition:
- Shared package `music_pkg`:
  - state encoding constants IDLE=2'd0, RECORD=2'd1, PLAY=2'd2;
  - `NOTE_ADDR_W` = 4;
  - `NOTE_DEPTH` = 16.
- One sub-module, `beat_timer`: parameterised period, `clear` and `enable` inputs, one-cycle `tick` output. It is reused for the gap timer with period `GAP_CYCLES`.

Test Plan:
- Reset then rec_req: reset high 2 cycles, then a rec_req pulse -> `busy_rec` = 1, `note_count` = 0, `ld_note` = 0.
- Record and play once: rec_req, then 3 `key_valid` pulses 5 cycles apart, `BEAT_CYCLES` = 4, `loop_en` = 0, then play_req.
  - During record: `ld_note` pulses exactly 3 times, each 1 cycle wide; `note_count` = 3.
  - During play: `note_counter` = 1,2,3, each held 4 cycles with a `beat` at each advance; then IDLE and `ld_play` = 0.
- Gap drop: in RECORD, `key_valid` on 2 consecutive cycles -> only one `ld_note`, `note_count` += 1.
- Saturation: 18 accepted-spacing key presses -> `note_count` = 16, exactly 16 `ld_note` pulses.
- Loop and stop: 16 stored notes, `loop_en` = 1.
  - `note_counter` sequence 1..15, 0, 1... (wraps).
  - stop_req mid-beat -> IDLE next cycle, `ld_play` = 0.
- Priority and reset mid-play: `stop_req` and `rec_req` in the same cycle -> IDLE. Reset asserted during PLAY -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/music_sequencer_ctrl_pkg.sv
// Shared encodings and sizes for the note-memory record/playback controller.
package music_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  localparam int NOTE_ADDR_W = 4;
  localparam int NOTE_DEPTH  = 16;
  localparam int COUNT_W     = NOTE_ADDR_W + 1;

  // The datapath writes its first note at address 1, so playback address
  // leads the playback index by one and wraps 15 -> 0.
  function automatic logic [NOTE_ADDR_W-1:0] play_addr(input logic [NOTE_ADDR_W-1:0] idx);
    return idx + 1'b1;
  endfunction

endpackage

// File: rtl/beat_timer.sv
// Free-running period counter; tick is high during the terminal count while enabled.
module beat_timer #(
  parameter int PERIOD = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] LAST = W'(PERIOD - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)       cnt_d = '0;
    else if (enable) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick = enable && (cnt_q == LAST);

endmodule

// File: rtl/music_sequencer_ctrl.sv
// Record/playback sequencer: spaces key presses into ld_note strobes and
// steps the playback address at a fixed tempo while holding ld_play.
module music_sequencer_ctrl
  import music_pkg::*;
#(
  parameter int BEAT_CYCLES = 12500000,
  parameter int DEPTH       = NOTE_DEPTH,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rec_req,
  input  logic                   play_req,
  input  logic                   stop_req,
  input  logic                   loop_en,
  input  logic                   key_valid,
  output logic                   ld_note,
  output logic                   ld_play,
  output logic [NOTE_ADDR_W-1:0] note_counter,
  output logic [COUNT_W-1:0]     note_count,
  output logic                   busy_rec,
  output logic                   busy_play,
  output logic                   beat
);

  state_e                 state_q, state_d;
  logic [COUNT_W-1:0]     count_q, count_d;
  logic [NOTE_ADDR_W-1:0] idx_q, idx_d;
  logic [NOTE_ADDR_W-1:0] addr_q, addr_d;
  logic                   ld_note_q, ld_note_d;
  logic                   beat_q, beat_d;
  logic                   ld_play_q, busy_rec_q, busy_play_q;
  logic                   gap_act_q, gap_act_d;

  logic gap_set, gap_tick, gap_open;
  logic play_entry, beat_tick, beat_clr, last_note;

  // Gap window: opens on the timer's terminal cycle so strobes can be
  // exactly GAP_CYCLES apart while never being adjacent.
  beat_timer #(.PERIOD(GAP_CYCLES)) u_gap (
    .clk    (clk),
    .reset  (reset),
    .clear  (gap_set),
    .enable (gap_act_q),
    .tick   (gap_tick)
  );

  beat_timer #(.PERIOD(BEAT_CYCLES)) u_beat (
    .clk    (clk),
    .reset  (reset),
    .clear  (beat_clr),
    .enable (state_q == PLAY),
    .tick   (beat_tick)
  );

  assign gap_open  = !gap_act_q || gap_tick;
  assign last_note = ({1'b0, idx_q} + 5'd1) == count_q;
  assign beat_clr  = (state_d != PLAY) || play_entry;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    ld_note_d  = 1'b0;
    beat_d     = 1'b0;
    gap_set    = 1'b0;
    play_entry = 1'b0;

    case (state_q)
      IDLE: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (rec_req) begin
          state_d = RECORD;
          count_d = '0;
        end else if (play_req && count_q != '0) begin
          play_entry = 1'b1;
        end
      end
      RECORD: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (rec_req) begin
          count_d = '0;
        end else if (play_req && count_q != '0) begin
          play_entry = 1'b1;
        end else if (key_valid && gap_open && count_q < COUNT_W'(DEPTH)) begin
          ld_note_d = 1'b1;
          count_d   = count_q + 1'b1;
          gap_set   = 1'b1;
        end
      end
      PLAY: begin
        if (stop_req) begin
          state_d = IDLE;
        end else if (rec_req) begin
          state_d = RECORD;
          count_d = '0;
        end else if (beat_tick) begin
          beat_d = 1'b1;
          if (!last_note) begin
            idx_d  = idx_q + 1'b1;
            addr_d = play_addr(idx_d);
          end else if (loop_en) begin
            idx_d  = '0;
            addr_d = play_addr('0);
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (play_entry) begin
      state_d = PLAY;
      idx_d   = '0;
      addr_d  = play_addr('0);
    end
  end

  always_comb begin
    gap_act_d = gap_act_q;
    if (gap_set)       gap_act_d = 1'b1;
    else if (gap_tick) gap_act_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      idx_q       <= '0;
      addr_q      <= '0;
      ld_note_q   <= 1'b0;
      beat_q      <= 1'b0;
      ld_play_q   <= 1'b0;
      busy_rec_q  <= 1'b0;
      busy_play_q <= 1'b0;
      gap_act_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      ld_note_q   <= ld_note_d;
      beat_q      <= beat_d;
      ld_play_q   <= (state_d == PLAY);
      busy_rec_q  <= (state_d == RECORD);
      busy_play_q <= (state_d == PLAY);
      gap_act_q   <= gap_act_d;
    end
  end

  assign ld_note      = ld_note_q;
  assign ld_play      = ld_play_q;
  assign note_counter = addr_q;
  assign note_count   = count_q;
  assign busy_rec     = busy_rec_q;
  assign busy_play    = busy_play_q;
  assign beat         = beat_q;

endmodule

// File: tb/tb_music_sequencer_ctrl.sv
// Directed checks of record spacing, saturation, playback tempo, looping and aborts.
module tb_music_sequencer_ctrl;

  logic       clk = 1'b0;
  logic       reset, rec_req, play_req, stop_req, loop_en, key_valid;
  logic       ld_note, ld_play, busy_rec, busy_play, beat;
  logic [3:0] note_counter;
  logic [4:0] note_count;

  int checks = 0;
  int errors = 0;
  int ld_cnt = 0, beat_cnt = 0, adj_viol = 0, ovl_viol = 0;
  logic prev_ld = 1'b0;
  int n0, b0;

  music_sequencer_ctrl #(.BEAT_CYCLES(4), .DEPTH(16), .GAP_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rec_req      (rec_req),
    .play_req     (play_req),
    .stop_req     (stop_req),
    .loop_en      (loop_en),
    .key_valid    (key_valid),
    .ld_note      (ld_note),
    .ld_play      (ld_play),
    .note_counter (note_counter),
    .note_count   (note_count),
    .busy_rec     (busy_rec),
    .busy_play    (busy_play),
    .beat         (beat)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ld_note) ld_cnt++;
    if (beat) beat_cnt++;
    if (ld_note && prev_ld) adj_viol++;
    if (ld_note && ld_play) ovl_viol++;
    prev_ld = ld_note;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld_note"}, ld_note, 0);
    chk({tag, "_ld_play"}, ld_play, 0);
    chk({tag, "_beat"}, beat, 0);
    chk({tag, "_busy_rec"}, busy_rec, 0);
    chk({tag, "_busy_play"}, busy_play, 0);
    chk({tag, "_note_counter"}, note_counter, 0);
    chk({tag, "_note_count"}, note_count, 0);
  endtask

  initial begin
    reset = 1'b1; rec_req = 1'b0; play_req = 1'b0; stop_req = 1'b0;
    loop_en = 1'b0; key_valid = 1'b0;
    tick(2);
    chk_reset_vals("rst");
    reset = 1'b0;
    tick(1);

    // enter record
    rec_req = 1'b1; tick(1); rec_req = 1'b0;
    chk("rec_busy", busy_rec, 1);
    chk("rec_count0", note_count, 0);
    chk("rec_ld0", ld_note, 0);

    // three keys, 5 cycles apart
    n0 = ld_cnt;
    for (int k = 0; k < 3; k++) begin
      key_valid = 1'b1; tick(1); key_valid = 1'b0;
      chk($sformatf("key%0d_ld", k), ld_note, 1);
      chk($sformatf("key%0d_cnt", k), note_count, k + 1);
      tick(1);
      chk($sformatf("key%0d_ld_low", k), ld_note, 0);
      tick(3);
    end
    chk("rec3_pulses", ld_cnt - n0, 3);

    // play once, 4 cycles per note
    loop_en = 1'b0;
    b0 = beat_cnt;
    play_req = 1'b1; tick(1); play_req = 1'b0;
    chk("play_ld_play", ld_play, 1);
    chk("play_busy", busy_play, 1);
    for (int n = 1; n <= 3; n++) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("play_n%0d_c%0d", n, c), note_counter, n);
        if (c == 0) chk($sformatf("play_beat_n%0d", n), beat, (n > 1) ? 1 : 0);
        if (c == 1) chk($sformatf("play_beat_low_n%0d", n), beat, 0);
        tick(1);
      end
    end
    chk("play_end_ld_play", ld_play, 0);
    chk("play_end_busy", busy_play, 0);
    chk("play_end_addr_held", note_counter, 3);
    tick(1);
    chk("play_beats", beat_cnt - b0, 3);

    // back-to-back key presses: second one dropped
    rec_req = 1'b1; tick(1); rec_req = 1'b0;
    n0 = ld_cnt;
    key_valid = 1'b1; tick(2); key_valid = 1'b0;
    tick(3);
    chk("gap_pulses", ld_cnt - n0, 1);
    chk("gap_count", note_count, 1);

    // saturation at 16
    rec_req = 1'b1; tick(1); rec_req = 1'b0;
    n0 = ld_cnt;
    for (int k = 0; k < 18; k++) begin
      key_valid = 1'b1; tick(1); key_valid = 1'b0;
      tick(2);
    end
    tick(1);
    chk("sat_count", note_count, 16);
    chk("sat_pulses", ld_cnt - n0, 16);

    // loop through 16 notes with address wrap, then stop mid-beat
    loop_en = 1'b1;
    play_req = 1'b1; tick(1); play_req = 1'b0;
    for (int j = 0; j < 18; j++) begin
      chk($sformatf("loop_addr%0d", j), note_counter, ((j % 16) + 1) % 16);
      tick(4);
    end
    tick(2);
    stop_req = 1'b1; tick(1); stop_req = 1'b0;
    chk("stop_ld_play", ld_play, 0);
    chk("stop_busy", busy_play, 0);
    chk("stop_addr_held", note_counter, 3);
    chk("stop_count_kept", note_count, 16);
    loop_en = 1'b0;

    // stop beats record when both requested
    play_req = 1'b1; tick(1); play_req = 1'b0;
    chk("prio_in_play", busy_play, 1);
    tick(3);
    stop_req = 1'b1; rec_req = 1'b1; tick(1);
    stop_req = 1'b0; rec_req = 1'b0;
    chk("prio_busy_rec", busy_rec, 0);
    chk("prio_busy_play", busy_play, 0);
    chk("prio_count_kept", note_count, 16);

    // reset mid-play
    play_req = 1'b1; tick(1); play_req = 1'b0;
    tick(5);
    chk("pre_rst_play", ld_play, 1);
    reset = 1'b1; tick(1);
    chk_reset_vals("midplay_rst");
    reset = 1'b0;

    // play with nothing recorded is ignored
    play_req = 1'b1; tick(1); play_req = 1'b0;
    chk("empty_play_busy", busy_play, 0);
    chk("empty_play_ld", ld_play, 0);

    tick(1);
    chk("ld_note_adjacent", adj_viol, 0);
    chk("ld_note_play_overlap", ovl_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
